// File: rtl/rst_sequencer.sv
// rst_sequencer: stretched, registered active-high reset from system reset, soft request and lock (option: RSTSEQ_LOCK_WAIT_EN)
module rst_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int LOCK_FILTER = 4
) (
    input  logic       Clk_i,
    input  logic       Rst_i,
    input  logic       SoftRstReq_i,
    input  logic       Locked_i,
    output logic       Rst_o,
    output logic       RstDone_o,
    output logic [1:0] State_o
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam int LW = LOCK_FILTER > 1 ? $clog2(LOCK_FILTER) : 1;
`ifdef RSTSEQ_LOCK_WAIT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {RESET = 2'd0, WAIT_LOCK = 2'd1, HOLD = 2'd2, RUN = 2'd3} state_t;

    state_t state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [LW-1:0] lock_cnt, lock_nxt;
    logic req_prev, req_edge, lost, rst_nxt, done_nxt;

    assign req_edge = SoftRstReq_i & ~req_prev;
    assign lost     = LOCK_EN & ~Locked_i;
    assign State_o  = state;

    // state, counters and registered outputs; reqPrev starts high so a request held through reset cannot retrigger
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state     <= RESET;
            hold_cnt  <= '0;
            lock_cnt  <= '0;
            req_prev  <= 1'b1;
            Rst_o     <= 1'b1;
            RstDone_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            lock_cnt  <= lock_nxt;
            req_prev  <= SoftRstReq_i;
            Rst_o     <= rst_nxt;
            RstDone_o <= done_nxt;
        end
    end

    // sequencing rules; lock loss outranks a soft request, and counters restart on every state entry
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        lock_nxt  = lock_cnt;
        case (state)
            RESET: begin
                state_nxt = LOCK_EN ? WAIT_LOCK : HOLD;
                hold_nxt  = '0;
                lock_nxt  = '0;
            end
            WAIT_LOCK: begin
                if (!Locked_i) lock_nxt = '0;
                else if (lock_cnt == LW'(LOCK_FILTER - 1)) begin
                    state_nxt = HOLD;
                    hold_nxt  = '0;
                end else lock_nxt = lock_cnt + 1'b1;
            end
            HOLD: begin
                if (lost) begin
                    state_nxt = WAIT_LOCK;
                    lock_nxt  = '0;
                end else if (req_edge) hold_nxt = '0;
                else if (hold_cnt == HW'(HOLD_CYCLES - 1)) state_nxt = RUN;
                else hold_nxt = hold_cnt + 1'b1;
            end
            default: begin
                if (lost) begin
                    state_nxt = WAIT_LOCK;
                    lock_nxt  = '0;
                end else if (req_edge) begin
                    state_nxt = HOLD;
                    hold_nxt  = '0;
                end
            end
        endcase
    end

    // reset is high everywhere except RUN; done pulses on the HOLD->RUN edge only
    always_comb begin
        rst_nxt  = state_nxt != RUN;
        done_nxt = state == HOLD && state_nxt == RUN;
    end
endmodule
